// File: rtl/carfield_eoc_collector.sv
// Multi-domain end-of-computation collector: arms on start, latches one EOC return code
// per enabled channel, flags failures and finishes in DONE or TIMEOUT.
module carfield_eoc_collector #(
  parameter  int unsigned NumChannels  = 4,
  parameter  int unsigned RetWidth     = 32,
  parameter  int unsigned TimeoutWidth = 32,
  localparam int unsigned CodeWidth    = RetWidth - 1,
  localparam int unsigned IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NumChannels-1:0]           chan_mask_i,
  input  logic [TimeoutWidth-1:0]          timeout_i,
  input  logic [NumChannels-1:0]           eoc_valid_i,
  input  logic [NumChannels*RetWidth-1:0]  eoc_data_i,
  output logic [NumChannels-1:0]           eoc_ready_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic                             fail_o,
  output logic [NumChannels-1:0]           seen_o,
  output logic [NumChannels*CodeWidth-1:0] ret_o,
  output logic [IdxWidth-1:0]              first_fail_o,
  output logic [TimeoutWidth-1:0]          cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e                       state_r, state_n_s;
  logic [NumChannels-1:0]       mask_r, seen_r, seen_n_s, accept_s, bad_s;
  logic [TimeoutWidth-1:0]      timeout_r, cycles_r, cycles_plus_s, cycles_n_s;
  logic [NumChannels*CodeWidth-1:0] ret_r;
  logic                         fail_r;
  logic [IdxWidth-1:0]          first_fail_r, bad_idx_s;
  logic                         covered_s, expire_s;

  assign eoc_ready_o  = (state_r == ST_ARMED) ? (mask_r & ~seen_r) : {NumChannels{1'b0}};
  assign busy_o       = (state_r == ST_ARMED);
  assign done_o       = (state_r == ST_DONE);
  assign timeout_o    = (state_r == ST_TIMEOUT);
  assign fail_o       = fail_r;
  assign seen_o       = seen_r;
  assign ret_o        = ret_r;
  assign first_fail_o = first_fail_r;
  assign cycles_o     = cycles_r;

  // Classify this cycle's handshakes; descending scan leaves the lowest failing index.
  always_comb begin
    accept_s  = {NumChannels{1'b0}};
    bad_s     = {NumChannels{1'b0}};
    bad_idx_s = {IdxWidth{1'b0}};
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (eoc_ready_o[i] && eoc_valid_i[i] && eoc_data_i[i*RetWidth]) begin
        accept_s[i] = 1'b1;
        if (eoc_data_i[i*RetWidth+1 +: CodeWidth] != {CodeWidth{1'b0}}) begin
          bad_s[i]  = 1'b1;
          bad_idx_s = IdxWidth'(i);
        end else begin
          bad_s[i]  = 1'b0;
        end
      end else begin
        accept_s[i] = 1'b0;
      end
    end
  end

  assign seen_n_s      = seen_r | accept_s;
  assign covered_s     = ((seen_n_s & mask_r) == mask_r);
  assign cycles_plus_s = cycles_r + {{(TimeoutWidth-1){1'b0}}, 1'b1};
  assign cycles_n_s    = (&cycles_r) ? cycles_r : cycles_plus_s;
  assign expire_s      = (timeout_r != {TimeoutWidth{1'b0}}) && (cycles_plus_s == timeout_r);

  // Next-state logic; completion is checked before expiry so a last-cycle report wins.
  always_comb begin
    state_n_s = state_r;
    if (clear_i) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start_i) begin
            state_n_s = ST_ARMED;
          end else begin
            state_n_s = state_r;
          end
        end
        ST_ARMED: begin
          if (covered_s) begin
            state_n_s = ST_DONE;
          end else if (expire_s) begin
            state_n_s = ST_TIMEOUT;
          end else begin
            state_n_s = ST_ARMED;
          end
        end
        default: state_n_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Arm-time configuration latch and per-channel status collection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_r       <= {NumChannels{1'b0}};
      timeout_r    <= {TimeoutWidth{1'b0}};
      seen_r       <= {NumChannels{1'b0}};
      ret_r        <= {(NumChannels*CodeWidth){1'b0}};
      fail_r       <= 1'b0;
      first_fail_r <= {IdxWidth{1'b0}};
      cycles_r     <= {TimeoutWidth{1'b0}};
    end else if (clear_i) begin
      mask_r       <= {NumChannels{1'b0}};
      timeout_r    <= {TimeoutWidth{1'b0}};
      seen_r       <= {NumChannels{1'b0}};
      ret_r        <= {(NumChannels*CodeWidth){1'b0}};
      fail_r       <= 1'b0;
      first_fail_r <= {IdxWidth{1'b0}};
      cycles_r     <= {TimeoutWidth{1'b0}};
    end else begin
      case (state_r)
        ST_ARMED: begin
          seen_r   <= seen_n_s;
          cycles_r <= cycles_n_s;
          for (int i = 0; i < NumChannels; i++) begin
            if (accept_s[i]) begin
              ret_r[i*CodeWidth +: CodeWidth] <= eoc_data_i[i*RetWidth+1 +: CodeWidth];
            end
          end
          if (!fail_r && (|bad_s)) begin
            fail_r       <= 1'b1;
            first_fail_r <= bad_idx_s;
          end
        end
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start_i) begin
            mask_r       <= chan_mask_i;
            timeout_r    <= timeout_i;
            seen_r       <= {NumChannels{1'b0}};
            ret_r        <= {(NumChannels*CodeWidth){1'b0}};
            fail_r       <= 1'b0;
            first_fail_r <= {IdxWidth{1'b0}};
            cycles_r     <= {TimeoutWidth{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_eoc_collector.sv
// Self-checking bench for carfield_eoc_collector: directed table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_carfield_eoc_collector;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         clear_i = 1'b0;
  logic [3:0]   chan_mask_i = 4'h0;
  logic [31:0]  timeout_i = 32'h0;
  logic [3:0]   eoc_valid_i = 4'h0;
  logic [127:0] eoc_data_i = 128'h0;
  logic [3:0]   eoc_ready_o;
  logic         busy_o, done_o, timeout_o, fail_o;
  logic [3:0]   seen_o;
  logic [123:0] ret_o;
  logic [1:0]   first_fail_o;
  logic [31:0]  cycles_o;

  int n_vec  = 0;
  int n_miss = 0;

  carfield_eoc_collector dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .chan_mask_i(chan_mask_i), .timeout_i(timeout_i),
    .eoc_valid_i(eoc_valid_i), .eoc_data_i(eoc_data_i), .eoc_ready_o(eoc_ready_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .fail_o(fail_o),
    .seen_o(seen_o), .ret_o(ret_o), .first_fail_o(first_fail_o), .cycles_o(cycles_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         start, clear;
    logic [3:0]   mask;
    logic [31:0]  tmo;
    logic [3:0]   valid;
    logic [127:0] data;
    logic [3:0]   exp_ready;  // before the edge
    logic [2:0]   exp_bdt;    // {busy, done, timeout} after the edge
    logic         exp_fail;
    logic [3:0]   exp_seen;
    logic [1:0]   exp_ff;
  } vec_t;

  function automatic vec_t mkv(logic st, logic cl, logic [3:0] mk, logic [31:0] to,
                               logic [3:0] v, logic [127:0] d, logic [3:0] rdy,
                               logic [2:0] bdt, logic fl, logic [3:0] sn, logic [1:0] ff);
    vec_t r;
    r.start = st; r.clear = cl; r.mask = mk; r.tmo = to; r.valid = v; r.data = d;
    r.exp_ready = rdy; r.exp_bdt = bdt; r.exp_fail = fl; r.exp_seen = sn; r.exp_ff = ff;
    return r;
  endfunction

  function automatic logic [127:0] dat(logic [31:0] c3, logic [31:0] c2, logic [31:0] c1, logic [31:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic cl, input logic [3:0] mk, input logic [31:0] to,
                       input logic [3:0] v, input logic [127:0] d);
    start_i = st; clear_i = cl; chan_mask_i = mk; timeout_i = to; eoc_valid_i = v; eoc_data_i = d;
  endtask

  task automatic step(input logic st, input logic cl, input logic [3:0] mk, input logic [31:0] to,
                      input logic [3:0] v, input logic [127:0] d);
    @(negedge clk_i);
    drive(st, cl, mk, to, v, d);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 128'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bdt"},   {busy_o, done_o, timeout_o}, 3'b000);
    check({tag, "_fail"},  fail_o, 1'b0);
    check({tag, "_seen"},  seen_o, 4'h0);
    check({tag, "_ret"},   ret_o, 124'h0);
    check({tag, "_ff"},    first_fail_o, 2'd0);
    check({tag, "_cyc"},   cycles_o, 32'h0);
    check({tag, "_ready"}, eoc_ready_o, 4'h0);
  endtask

  // Behavioural model: states 0 idle, 1 armed, 2 done, 3 timeout
  int              m_st;
  bit [3:0]        m_mask, m_seen;
  bit [31:0]       m_to;
  bit [30:0]       m_ret [4];
  bit              m_fail;
  int              m_ff;
  longint unsigned m_cyc;

  function automatic void model_reset();
    m_st = 0; m_mask = 4'h0; m_seen = 4'h0; m_to = 32'h0; m_fail = 1'b0; m_ff = 0; m_cyc = 0;
    for (int c = 0; c < 4; c++) m_ret[c] = 31'h0;
  endfunction

  function automatic void model_step(input bit st, input bit cl, input bit [3:0] mk, input bit [31:0] to,
                                     input bit [3:0] v, input bit [127:0] d);
    int fails[$];
    if (cl) begin
      model_reset();
      return;
    end
    if (m_st == 1) begin
      for (int c = 0; c < 4; c++) begin
        if (m_mask[c] && !m_seen[c] && v[c] && d[c*32]) begin
          m_seen[c] = 1'b1;
          m_ret[c]  = d[c*32+1 +: 31];
          if (m_ret[c] != 31'h0) fails.push_back(c);
        end
      end
      if (!m_fail && fails.size() > 0) begin
        m_fail = 1'b1;
        m_ff   = fails[0];
      end
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if ((m_seen & m_mask) == m_mask) m_st = 2;
      else if (m_to != 0 && m_cyc == m_to) m_st = 3;
    end else if (st) begin
      model_reset();
      m_mask = mk; m_to = to; m_st = 1;
    end
  endfunction

  task automatic cmp_model();
    check("rnd_busy",    busy_o, (m_st == 1));
    check("rnd_done",    done_o, (m_st == 2));
    check("rnd_timeout", timeout_o, (m_st == 3));
    check("rnd_fail",    fail_o, m_fail);
    check("rnd_seen",    seen_o, m_seen);
    check("rnd_ff",      first_fail_o, m_ff);
    check("rnd_cycles",  cycles_o, m_cyc);
    check("rnd_ready",   eoc_ready_o, (m_st == 1) ? (m_mask & ~m_seen) : 4'h0);
    for (int c = 0; c < 4; c++) check("rnd_ret", ret_o[c*31 +: 31], m_ret[c]);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = mkv(1, 0, 4'b1111, 0, 4'b0000, 128'h0,               4'b0000, 3'b100, 0, 4'b0000, 0);
    tbl[1] = mkv(0, 0, 4'b0000, 0, 4'b1010, dat(5, 0, 7, 0),      4'b1111, 3'b100, 1, 4'b1010, 1);
    tbl[2] = mkv(0, 0, 4'b0000, 0, 4'b0101, dat(0, 1, 0, 3),      4'b0101, 3'b010, 1, 4'b1111, 1);
    tbl[3] = mkv(0, 0, 4'b0000, 0, 4'b0000, 128'h0,               4'b0000, 3'b010, 1, 4'b1111, 1);
    tbl[4] = mkv(1, 0, 4'b0111, 0, 4'b0000, 128'h0,               4'b0000, 3'b100, 0, 4'b0000, 0);
    tbl[5] = mkv(1, 0, 4'b1111, 0, 4'b1100, dat(1, 8, 0, 0),      4'b0111, 3'b100, 0, 4'b0000, 0);
    tbl[6] = mkv(0, 0, 4'b0000, 0, 4'b1100, dat(1, 9, 0, 0),      4'b0111, 3'b100, 1, 4'b0100, 2);
    tbl[7] = mkv(0, 0, 4'b0000, 0, 4'b1011, dat(1, 0, 1, 1),      4'b0011, 3'b010, 1, 4'b0111, 2);
    tbl[8] = mkv(1, 0, 4'b0000, 0, 4'b0000, 128'h0,               4'b0000, 3'b100, 0, 4'b0000, 0);
    tbl[9] = mkv(0, 0, 4'b0000, 0, 4'b0000, 128'h0,               4'b0000, 3'b010, 0, 4'b0000, 0);

    #12;
    check_zero("in_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_zero("after_reset");

    // Directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      drive(tbl[i].start, tbl[i].clear, tbl[i].mask, tbl[i].tmo, tbl[i].valid, tbl[i].data);
      #1;
      check($sformatf("tbl%0d_ready", i), eoc_ready_o, tbl[i].exp_ready);
      @(posedge clk_i);
      #1;
      check($sformatf("tbl%0d_bdt", i),  {busy_o, done_o, timeout_o}, tbl[i].exp_bdt);
      check($sformatf("tbl%0d_fail", i), fail_o, tbl[i].exp_fail);
      check($sformatf("tbl%0d_seen", i), seen_o, tbl[i].exp_seen);
      check($sformatf("tbl%0d_ff", i),   first_fail_o, tbl[i].exp_ff);
      if (i == 7) check("tbl7_ret2", ret_o[2*31 +: 31], 31'd4);
    end

    // Two reports ten cycles apart, both passing
    step(0, 1, 4'h0, 0, 4'h0, 128'h0);
    step(1, 0, 4'b0101, 0, 4'h0, 128'h0);
    step(0, 0, 4'h0, 0, 4'b0001, dat(0, 0, 0, 1));
    repeat (10) idle();
    check("t1_busy", busy_o, 1'b1);
    step(0, 0, 4'h0, 0, 4'b0100, dat(0, 1, 0, 0));
    check("t1_done",   done_o, 1'b1);
    check("t1_fail",   fail_o, 1'b0);
    check("t1_ret",    ret_o, 124'h0);
    check("t1_seen",   seen_o, 4'b0101);
    check("t1_cycles", cycles_o, 32'd12);

    // Timeout after 20 armed cycles with one channel missing
    step(1, 0, 4'b0011, 32'd20, 4'h0, 128'h0);
    step(0, 0, 4'h0, 0, 4'b0001, dat(0, 0, 0, 1));
    repeat (18) idle();
    check("t3_busy19", {busy_o, timeout_o}, 2'b10);
    check("t3_cyc19",  cycles_o, 32'd19);
    idle();
    check("t3_bdt",    {busy_o, done_o, timeout_o}, 3'b001);
    check("t3_cycles", cycles_o, 32'd20);
    check("t3_seen",   seen_o, 4'b0001);
    repeat (2) idle();
    check("t3_hold",   {timeout_o, cycles_o}, {1'b1, 32'd20});

    // Last report on the expiry cycle: completion wins
    step(1, 0, 4'b0011, 32'd20, 4'h0, 128'h0);
    step(0, 0, 4'h0, 0, 4'b0001, dat(0, 0, 0, 1));
    repeat (18) idle();
    step(0, 0, 4'h0, 0, 4'b0010, dat(0, 0, 1, 0));
    check("t4_bdt",    {busy_o, done_o, timeout_o}, 3'b010);
    check("t4_cycles", cycles_o, 32'd20);

    // Clear mid-armed
    step(1, 0, 4'b1111, 0, 4'h0, 128'h0);
    step(0, 0, 4'h0, 0, 4'b0001, dat(0, 0, 0, 3));
    check("t6_fail_pre", fail_o, 1'b1);
    step(0, 1, 4'h0, 0, 4'h0, 128'h0);
    check_zero("t6_clear");

    // Reset mid-armed takes effect without a clock edge
    step(1, 0, 4'b1111, 0, 4'h0, 128'h0);
    step(0, 0, 4'h0, 0, 4'b0010, dat(0, 0, 5, 0));
    check("t6_ff_pre", {fail_o, first_fail_o}, 3'b101);
    @(negedge clk_i);
    drive(0, 0, 4'h0, 0, 4'h0, 128'h0);
    rst_i = 1'b1;
    #1;
    check_zero("t6_rst");
    #1;
    rst_i = 1'b0;
    model_reset();

    // Randomized run against the model
    for (int k = 0; k < 2000; k++) begin
      logic         st, cl;
      logic [3:0]   mk, v;
      logic [31:0]  to;
      logic [127:0] d;
      @(negedge clk_i);
      cmp_model();
      st = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 59) == 0);
      mk = 4'($urandom);
      to = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(1, 30));
      v  = 4'($urandom & $urandom & $urandom);
      d  = 128'h0;
      for (int c = 0; c < 4; c++) begin
        logic [30:0] code;
        code = ($urandom_range(0, 1) == 0) ? 31'h0 :
               (($urandom_range(0, 3) == 0) ? 31'($urandom) : 31'($urandom_range(1, 15)));
        d[c*32 +: 32] = {code, ($urandom_range(0, 3) != 0)};
      end
      drive(st, cl, mk, to, v, d);
      model_step(st, cl, mk, to, v, d);
    end
    @(negedge clk_i);
    cmp_model();
    drive(0, 0, 4'h0, 0, 4'h0, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
